// File: rtl/sync_barrier_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_barrier_ctrl
//  Description : Kernel-level sequencer. Launches a kernel on a mask of cores,
//                holds cores at SYNC until every still-running core has
//                arrived, retires cores on EXIT and flags kernel completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_barrier_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] sync_req,
    input  logic [NUM_CORES-1:0] exit_req,
    output logic [NUM_CORES-1:0] core_en,
    output logic [NUM_CORES-1:0] core_stall,
    output logic                 barrier_release,
    output logic [CNT_WIDTH-1:0] barrier_count,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 busy,
    output logic                 kernel_done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [NUM_CORES-1:0] r_launched;
    logic [NUM_CORES-1:0] r_exited;
    logic [NUM_CORES-1:0] r_arrived;
    logic [NUM_CORES-1:0] r_core_en;
    logic                 r_barrier_release;
    logic [CNT_WIDTH-1:0] r_barrier_count;
    logic [CNT_WIDTH-1:0] r_cycle_count;

    // ------------------------------------------------------------------------
    // Combinational request qualification and barrier evaluation
    // ------------------------------------------------------------------------
    logic                 w_in_run;
    logic                 w_launch;
    logic [NUM_CORES-1:0] w_running;
    logic [NUM_CORES-1:0] w_exit_acc;
    logic [NUM_CORES-1:0] w_sync_acc;
    logic [NUM_CORES-1:0] w_run_next;
    logic [NUM_CORES-1:0] w_arr_next;
    logic                 w_release_now;
    logic                 w_all_exited;

    assign w_in_run   = (r_state == c_RUN);
    // start is only honoured while no kernel is active
    assign w_launch   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_running  = r_launched & ~r_exited;

    // Requests only count for cores that are still running; exit beats sync
    // when a core raises both in the same cycle.
    assign w_exit_acc = w_in_run ? (exit_req & w_running) : '0;
    assign w_sync_acc = w_in_run ? (sync_req & w_running & ~exit_req) : '0;

    // Population of the barrier as it will stand after this cycle's exits.
    assign w_run_next = w_running & ~w_exit_acc;
    assign w_arr_next = (r_arrived | w_sync_acc) & w_run_next;

    // A barrier completes when every surviving core has arrived. This also
    // covers the case where the last straggler exits instead of syncing.
    assign w_release_now = w_in_run
                        && (w_run_next != '0)
                        && (w_arr_next != '0)
                        && (w_arr_next == w_run_next);

    // Kernel ends once no core is left running; waiting cores get no release.
    assign w_all_exited = w_in_run && (w_run_next == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_state_next = (core_mask != '0) ? c_RUN : c_DONE;
                end
            end
            c_RUN: begin
                if (w_all_exited) begin
                    w_state_next = c_DONE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Per-core tracking, enables, release pulse and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_launched        <= '0;
            r_exited          <= '0;
            r_arrived         <= '0;
            r_core_en         <= '0;
            r_barrier_release <= 1'b0;
            r_barrier_count   <= '0;
            r_cycle_count     <= '0;
        end else if (w_launch) begin
            // A zero mask still clears counters and lands directly in DONE,
            // where the enables are forced low.
            r_launched        <= core_mask;
            r_exited          <= '0;
            r_arrived         <= '0;
            r_core_en         <= core_mask;
            r_barrier_release <= 1'b0;
            r_barrier_count   <= '0;
            r_cycle_count     <= '0;
        end else if (w_in_run) begin
            r_exited  <= r_exited | w_exit_acc;
            r_core_en <= w_run_next;
            if (r_cycle_count != c_CNT_MAX) begin
                r_cycle_count <= r_cycle_count + c_CNT_ONE;
            end
            if (w_release_now) begin
                r_arrived         <= '0;
                r_barrier_release <= 1'b1;
                r_barrier_count   <= r_barrier_count + c_CNT_ONE;
            end else begin
                // w_arr_next is already empty when the kernel is finishing
                r_arrived         <= w_arr_next;
                r_barrier_release <= 1'b0;
            end
        end else begin
            r_core_en         <= '0;
            r_barrier_release <= 1'b0;
        end
    end

    // Output decode: status from state, stall from arrivals and live syncs
    always_comb begin
        core_en         = r_core_en;
        barrier_release = r_barrier_release;
        barrier_count   = r_barrier_count;
        cycle_count     = r_cycle_count;
        busy            = (r_state == c_RUN);
        kernel_done     = (r_state == c_DONE);
        // The completing cycle unstalls everyone, so the last arriver never
        // sees a stall and the waiters resume without an extra bubble.
        core_stall      = '0;
        if (w_in_run) begin
            core_stall = (r_arrived | w_sync_acc) & ~{NUM_CORES{w_release_now}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_barrier_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sync_barrier_ctrl
//  Description : Directed self-checking bench for sync_barrier_ctrl with a
//                FIFO scoreboard of expected output values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_barrier_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] core_mask;
    logic [3:0] sync_req;
    logic [3:0] exit_req;
    logic [3:0] core_en;
    logic [3:0] core_stall;
    logic       barrier_release;
    logic [15:0] barrier_count;
    logic [15:0] cycle_count;
    logic       busy;
    logic       kernel_done;

    // narrow-counter instance for the boundary checks
    logic       rst4;
    logic       start4;
    logic [3:0] mask4;
    logic [3:0] sync4;
    logic [3:0] exit4;
    logic [3:0] en4;
    logic [3:0] stall4;
    logic       rel4;
    logic [3:0] bc4;
    logic [3:0] cc4;
    logic       busy4;
    logic       done4;

    int passed;
    int total;

    string       tq[$];
    logic [31:0] vq[$];

    sync_barrier_ctrl #(.NUM_CORES(4), .CNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .core_mask       (core_mask),
        .sync_req        (sync_req),
        .exit_req        (exit_req),
        .core_en         (core_en),
        .core_stall      (core_stall),
        .barrier_release (barrier_release),
        .barrier_count   (barrier_count),
        .cycle_count     (cycle_count),
        .busy            (busy),
        .kernel_done     (kernel_done)
    );

    sync_barrier_ctrl #(.NUM_CORES(4), .CNT_WIDTH(4)) dut4 (
        .clk             (clk),
        .rst             (rst4),
        .start           (start4),
        .core_mask       (mask4),
        .sync_req        (sync4),
        .exit_req        (exit4),
        .core_en         (en4),
        .core_stall      (stall4),
        .barrier_release (rel4),
        .barrier_count   (bc4),
        .cycle_count     (cc4),
        .busy            (busy4),
        .kernel_done     (done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_v(input string tag, input logic [31:0] v);
        tq.push_back(tag);
        vq.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       tag;
        logic [31:0] v;
        total++;
        if (vq.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            tag = tq.pop_front();
            v   = vq.pop_front();
            assert (obs === v) passed++;
            else $error("FAIL %s observed=%0h expected=%0h", tag, obs, v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; start = 1'b0; core_mask = '0; sync_req = '0; exit_req = '0;
        rst4 = 1'b1; start4 = 1'b0; mask4 = '0; sync4 = '0; exit4 = '0;
        expect_v("rst_core_en", 0);
        expect_v("rst_stall", 0);
        expect_v("rst_busy", 0);
        expect_v("rst_done", 0);
        expect_v("rst_release", 0);
        expect_v("rst_bcount", 0);
        expect_v("rst_ccount", 0);
        step();
        step();
        rst = 1'b0; rst4 = 1'b0;
        check_v(core_en); check_v(core_stall); check_v(busy); check_v(kernel_done);
        check_v(barrier_release); check_v(barrier_count); check_v(cycle_count);

        // ---- launch 1111, syncs at cycles 2, 5, 5, 9, exit all at 12 ----
        start = 1'b1; core_mask = 4'hF;
        expect_v("t1_launch_en", 4'hF);
        expect_v("t1_launch_busy", 1);
        step();
        start = 1'b0;
        check_v(core_en); check_v(busy);
        for (int c = 1; c <= 12; c++) begin
            sync_req = (c == 2) ? 4'h1 : (c == 5) ? 4'h6 : (c == 9) ? 4'h8 : 4'h0;
            exit_req = (c == 12) ? 4'hF : 4'h0;
            expect_v($sformatf("t1_stall_c%0d", c),
                     (c >= 2 && c < 5) ? 1 : (c >= 5 && c < 9) ? 7 : 0);
            expect_v($sformatf("t1_release_c%0d", c), (c == 10) ? 1 : 0);
            #1;
            check_v(core_stall); check_v(barrier_release);
            step();
        end
        sync_req = '0; exit_req = '0;
        expect_v("t1_done", 1);
        expect_v("t1_en_off", 0);
        expect_v("t1_busy_off", 0);
        expect_v("t1_cycles", 12);
        expect_v("t1_bcount", 1);
        check_v(kernel_done); check_v(core_en); check_v(busy);
        check_v(cycle_count); check_v(barrier_count);

        // ---- exit completes a barrier: mask 0111 ----
        start = 1'b1; core_mask = 4'h7;
        expect_v("t2_en", 4'h7);
        expect_v("t2_ccount_clr", 0);
        expect_v("t2_bcount_clr", 0);
        step();
        start = 1'b0;
        check_v(core_en); check_v(cycle_count); check_v(barrier_count);
        sync_req = 4'h3;
        expect_v("t2_stall_sync", 4'h3);
        #1; check_v(core_stall);
        step();
        sync_req = '0;
        expect_v("t2_stall_wait", 4'h3);
        #1; check_v(core_stall);
        step();
        exit_req = 4'h4;
        expect_v("t2_stall_exitrel", 0);
        #1; check_v(core_stall);
        step();
        exit_req = '0;
        expect_v("t2_release", 1);
        expect_v("t2_en_after", 4'h3);
        expect_v("t2_bcount", 1);
        check_v(barrier_release); check_v(core_en); check_v(barrier_count);
        exit_req = 4'h3;
        expect_v("t2_done", 1);
        step();
        exit_req = '0;
        check_v(kernel_done);

        // ---- sync and exit together: mask 0011 ----
        start = 1'b1; core_mask = 4'h3;
        step();
        start = 1'b0;
        sync_req = 4'h2; exit_req = 4'h2;
        expect_v("t3_stall_both", 0);
        #1; check_v(core_stall);
        step();
        sync_req = 4'h1; exit_req = '0;
        expect_v("t3_en", 4'h1);
        expect_v("t3_stall_immed", 0);
        #1; check_v(core_en); check_v(core_stall);
        step();
        sync_req = '0;
        expect_v("t3_release", 1);
        expect_v("t3_bcount", 1);
        check_v(barrier_release); check_v(barrier_count);
        exit_req = 4'h1;
        expect_v("t3_done", 1);
        step();
        exit_req = '0;
        check_v(kernel_done);

        // ---- zero mask, ignored sync, start during RUN ----
        start = 1'b1; core_mask = 4'h0;
        expect_v("t4_zero_done", 1);
        expect_v("t4_zero_ccount", 0);
        expect_v("t4_zero_en", 0);
        expect_v("t4_zero_busy", 0);
        expect_v("t4_zero_bcount", 0);
        step();
        start = 1'b0;
        check_v(kernel_done); check_v(cycle_count); check_v(core_en);
        check_v(busy); check_v(barrier_count);
        start = 1'b1; core_mask = 4'h1;
        step();
        start = 1'b0;
        sync_req = 4'h8;
        expect_v("t4_foreign_stall", 0);
        #1; check_v(core_stall);
        step();
        sync_req = '0;
        expect_v("t4_foreign_release", 0);
        expect_v("t4_foreign_bcount", 0);
        check_v(barrier_release); check_v(barrier_count);
        start = 1'b1; core_mask = 4'hF;
        expect_v("t4_norelaunch_en", 4'h1);
        expect_v("t4_norelaunch_ccount", 2);
        expect_v("t4_norelaunch_busy", 1);
        step();
        start = 1'b0;
        check_v(core_en); check_v(cycle_count); check_v(busy);

        // ---- reset mid-barrier ----
        exit_req = 4'h1;
        step();
        exit_req = '0;
        start = 1'b1; core_mask = 4'h7;
        step();
        start = 1'b0;
        sync_req = 4'h5;
        step();
        sync_req = '0;
        expect_v("t5_waiting", 4'h5);
        #1; check_v(core_stall);
        rst = 1'b1;
        expect_v("t5_rst_en", 0);
        expect_v("t5_rst_stall", 0);
        expect_v("t5_rst_busy", 0);
        expect_v("t5_rst_done", 0);
        expect_v("t5_rst_release", 0);
        expect_v("t5_rst_bcount", 0);
        expect_v("t5_rst_ccount", 0);
        step();
        rst = 1'b0;
        check_v(core_en); check_v(core_stall); check_v(busy); check_v(kernel_done);
        check_v(barrier_release); check_v(barrier_count); check_v(cycle_count);
        start = 1'b1; core_mask = 4'h3;
        expect_v("t5_relaunch_en", 4'h3);
        expect_v("t5_relaunch_busy", 1);
        expect_v("t5_relaunch_stall", 0);
        step();
        start = 1'b0;
        #1;
        check_v(core_en); check_v(busy); check_v(core_stall);

        // ---- 4-bit counters: saturation and wrap ----
        start4 = 1'b1; mask4 = 4'h1;
        step();
        start4 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            sync4 = 4'h1;
            if (k == 2) expect_v("t6_release_pulse", 1);
            if (k == 16) begin
                expect_v("t6_bcount_max", 15);
                expect_v("t6_ccount_sat", 15);
            end
            if (k == 17) begin
                expect_v("t6_bcount_wrap", 0);
                expect_v("t6_ccount_hold", 15);
            end
            #1;
            if (k == 2) check_v(rel4);
            if (k == 16 || k == 17) begin
                check_v(bc4); check_v(cc4);
            end
            step();
        end
        sync4 = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
